// File: rtl/alu_iter.sv
// Purpose: registered RISC-V integer reg-reg ALU; shifts use an iterative shifter of SHIFT_STEP bits/cycle.
// Latency: 1 cycle for add/sub/compare/logic and zero-amount shifts; 1 + ceil(amount/SHIFT_STEP) for shifts.
// Backpressure: the result holds in DONE until out_ready; in_ready = IDLE || (DONE && out_ready).
`timescale 1ns/1ps
module alu_iter #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ra,
  input  logic [XLEN-1:0] rb,
  input  logic            arith_mode,
  input  logic            logic_alt,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            unsigned_compare,
  output logic            signed_compare
);

  localparam int AW = $clog2(XLEN);
  // One extra bit so that SHIFT_STEP == XLEN is representable.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] sh_reg;
  logic [CW-1:0]   cnt;
  logic            sh_left;
  logic            sh_fill;

  logic            accept;
  logic            is_shift;
  logic [CW-1:0]   amt;
  logic            lt_u;
  logic            lt_s;
  logic [XLEN-1:0] alu_res;
  logic [CW-1:0]   step;
  logic [CW-1:0]   cnt_next;
  logic [XLEN:0]   ext_shr;
  logic [XLEN-1:0] shifted;

  // Combinational ready: a result being consumed frees the slot in the same cycle.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign amt      = {1'b0, rb[AW-1:0]};
  assign lt_u     = ra < rb;
  assign lt_s     = $signed(ra) < $signed(rb);

  // Single-cycle result; zero-amount shifts pass ra straight through.
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = arith_mode ? (ra - rb) : (ra + rb);
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
      3'b100:  alu_res = ra ^ rb;
      3'b110:  alu_res = ra | rb;
      3'b111:  alu_res = ra & rb;
      default: alu_res = ra;
    endcase
  end

  // One shifter step of min(cnt, SHIFT_STEP); right shifts refill with the latched fill bit.
  always_comb begin
    step     = (cnt < STEP_C) ? cnt : STEP_C;
    cnt_next = cnt - step;
    ext_shr  = $signed({sh_fill, sh_reg}) >>> step;
    shifted  = sh_left ? (sh_reg << step) : ext_shr[XLEN-1:0];
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      out_valid        <= 1'b0;
      result           <= '0;
      unsigned_compare <= 1'b0;
      signed_compare   <= 1'b0;
      sh_reg           <= '0;
      cnt              <= '0;
      sh_left          <= 1'b0;
      sh_fill          <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      unsigned_compare <= lt_u;
      signed_compare   <= lt_s;
      if (is_shift && (amt != '0)) begin
        sh_reg    <= ra;
        cnt       <= amt;
        sh_left   <= (funct3 == 3'b001);
        sh_fill   <= (funct3 == 3'b101) && logic_alt && ra[XLEN-1];
        state     <= SHIFT;
        out_valid <= 1'b0;
      end else begin
        result    <= alu_res;
        state     <= DONE;
        out_valid <= 1'b1;
      end
    end else begin
      case (state)
        SHIFT: begin
          sh_reg <= shifted;
          cnt    <= cnt_next;
          if (cnt_next == '0) begin
            result    <= shifted;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Purpose: scoreboard bench for alu_iter; reference model is plain arithmetic on the operation rules.
// Latency: each expected entry carries its required acceptance-to-valid latency.
// Backpressure: out_ready is held, released and randomized; stimulus waits on in_ready.
`timescale 1ns/1ps
module tb_alu_iter;

  localparam int XLEN = 32;
  localparam int SS   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] ra;
  logic [XLEN-1:0] rb;
  logic            arith_mode;
  logic            logic_alt;
  logic [2:0]      funct3;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            unsigned_compare;
  logic            signed_compare;

  alu_iter #(.XLEN(XLEN), .SHIFT_STEP(SS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ra(ra), .rb(rb), .arith_mode(arith_mode), .logic_alt(logic_alt), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .unsigned_compare(unsigned_compare), .signed_compare(signed_compare)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            u;
    logic            s;
    int              lat;
    int              acc;
    bit              seen;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_ready_en = 1'b0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: what the operation means, not how the block computes it.
  function automatic exp_t model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [2:0] f, input logic am, input logic la);
    exp_t e;
    int   amt;
    amt    = int'(b % XLEN);
    e.u    = a < b;
    e.s    = $signed(a) < $signed(b);
    e.acc  = 0;
    e.seen = 1'b0;
    case (f)
      3'd0:    e.res = am ? a - b : a + b;
      3'd1:    e.res = a << amt;
      3'd2:    e.res = {{(XLEN-1){1'b0}}, e.s};
      3'd3:    e.res = {{(XLEN-1){1'b0}}, e.u};
      3'd4:    e.res = a ^ b;
      3'd5:    e.res = la ? XLEN'($signed(a) >>> amt) : a >> amt;
      3'd6:    e.res = a | b;
      default: e.res = a & b;
    endcase
    e.lat = ((f == 3'd1 || f == 3'd5) && amt != 0) ? 1 + (amt + SS - 1) / SS : 1;
    return e;
  endfunction

  // Called at posedge+1; holds the op until it is accepted, returns at posedge+1 after acceptance.
  task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [2:0] f,
                       input logic am, input logic la, input bit track, output int acc);
    exp_t e;
    bit   done;
    done = 1'b0;
    acc  = -1;
    ra = a; rb = b; funct3 = f; arith_mode = am; logic_alt = la; in_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (track) begin
          e = model(a, b, f, am, la);
          e.acc = cyc;
          q.push_back(e);
        end
        acc  = cyc;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    ra = $urandom; rb = $urandom; funct3 = 3'($urandom); arith_mode = 1'($urandom); logic_alt = 1'($urandom);
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: op %0d never accepted, required acceptance within 400 cycles", f);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
  endtask

  // Monitor: checks first-valid latency, then data at the handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_output: out_valid=1 result=%h, required no output (cycle %0d)", result, cyc);
      end else begin
        if (!q[0].seen) begin
          chk("latency", XLEN'(cyc - q[0].acc), XLEN'(q[0].lat));
          q[0].seen = 1'b1;
        end
        if (out_ready && !flush) begin
          chk("result", result, q[0].res);
          chk("unsigned_compare", XLEN'(unsigned_compare), XLEN'(q[0].u));
          chk("signed_compare", XLEN'(signed_compare), XLEN'(q[0].s));
          void'(q.pop_front());
        end
      end
    end
  end

  // Random consumer backpressure, enabled only for the random phase.
  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish before 500000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    int   c0;
    exp_t e;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0] f;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ra = '0; rb = '0; funct3 = '0; arith_mode = 1'b0; logic_alt = 1'b0;
    #12;
    chk("reset_in_ready", XLEN'(in_ready), 1);
    chk("reset_out_valid", XLEN'(out_valid), 0);
    chk("reset_result", result, 0);
    chk("reset_ucmp", XLEN'(unsigned_compare), 0);
    chk("reset_scmp", XLEN'(signed_compare), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operations
    issue(32'h7FFFFFFF, 32'd1, 3'd0, 1'b0, 1'b0, 1, acc);
    issue(32'd5, 32'd7, 3'd0, 1'b1, 1'b0, 1, acc);
    issue(32'hFFFFFFFF, 32'd1, 3'd2, 1'b0, 1'b0, 1, acc);
    issue(32'hFFFFFFFF, 32'd1, 3'd3, 1'b0, 1'b0, 1, acc);
    issue(32'hF0F0F0F0, 32'hFF00FF00, 3'd4, 1'b0, 1'b0, 1, acc);
    issue(32'hF0F0F0F0, 32'hFF00FF00, 3'd6, 1'b0, 1'b0, 1, acc);
    issue(32'hF0F0F0F0, 32'hFF00FF00, 3'd7, 1'b0, 1'b0, 1, acc);
    issue(32'd1, 32'd5, 3'd1, 1'b0, 1'b0, 1, acc);
    issue(32'h80000000, 32'hFFFFFFFF, 3'd5, 1'b0, 1'b1, 1, acc);
    issue(32'h80000000, 32'hFFFFFFFF, 3'd5, 1'b0, 1'b0, 1, acc);
    issue(32'h12345678, 32'd32, 3'd1, 1'b0, 1'b0, 1, acc);
    issue(32'h80000000, 32'd4, 3'd5, 1'b0, 1'b1, 1, acc);
    drain();

    // Hold the result in DONE for three cycles, then retire and issue in the same cycle
    @(posedge clk); #1 out_ready = 1'b0;
    e = model(32'd5, 32'd7, 3'd0, 1'b1, 1'b0);
    issue(32'd5, 32'd7, 3'd0, 1'b1, 1'b0, 1, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_out_valid", XLEN'(out_valid), 1);
      chk("hold_result", result, e.res);
      chk("hold_ucmp", XLEN'(unsigned_compare), XLEN'(e.u));
      chk("hold_scmp", XLEN'(signed_compare), XLEN'(e.s));
      chk("hold_in_ready", XLEN'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    c0 = cyc;
    issue(32'hA5A5A5A5, 32'h0F0F0F0F, 3'd4, 1'b0, 1'b0, 1, acc);
    chk("same_cycle_accept", XLEN'(acc - c0), 0);
    drain();

    // Flush during the second SHIFT cycle
    @(posedge clk); #1;
    issue(32'h0000_0001, 32'd20, 3'd1, 1'b0, 1'b0, 0, acc);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", XLEN'(in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      chk("flush_no_output", XLEN'(out_valid), 0);
      @(negedge clk);
    end

    // Flush with a same-cycle request in IDLE discards the request
    @(posedge clk); #1;
    ra = 32'd3; rb = 32'd4; funct3 = 3'd0; arith_mode = 1'b0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_idle_no_output", XLEN'(out_valid), 0);
    end

    // Asynchronous reset in the middle of a shift
    @(posedge clk); #1;
    issue(32'hFFFF0000, 32'd30, 3'd5, 1'b0, 1'b1, 0, acc);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", XLEN'(in_ready), 1);
    chk("async_rst_out_valid", XLEN'(out_valid), 0);
    chk("async_rst_result", result, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Random operations with random consumer backpressure
    rand_ready_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: b = a;
        default: ;
      endcase
      issue(a, b, f, 1'($urandom), 1'($urandom), 1, acc);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_ready_en = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, registered successor to the single-cycle integer ALU. Executes one RISC-V integer register-register operation per transaction behind a valid/ready handshake. Add/sub, compare and logic results arrive one cycle after acceptance. Shifts run on an iterative shifter that moves up to SHIFT_STEP bit positions per cycle, so shift latency depends on the shift amount. The block sits between operand read and writeback in the execute stage and supports back-to-back issue and output backpressure.

## Interface
- XLEN, 32: datapath width; power of two, at least 8.
- SHIFT_STEP, 4: maximum bit positions shifted per cycle; power of two, 1 to XLEN.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort; drops any in-flight or completed operation.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  block accepts an operation this cycle.
- ra, rb  in  XLEN each  operands.
- arith_mode  in  1  selects sub when funct3=000.
- logic_alt  in  1  selects sra when funct3=101.
- funct3  in  3  operation select.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  operation result.
- unsigned_compare  out  1  ra < rb, unsigned, using the latched operands.
- signed_compare  out  1  ra < rb, signed, using the latched operands.

## Operation
- funct3 decode:
  - 000 add, or sub when arith_mode=1; wraps modulo 2^XLEN.
  - 001 sll.
  - 010 slt, result {0…,signed_compare}.
  - 011 sltu, result {0…,unsigned_compare}.
  - 100 xor.
  - 101 srl, or sra when logic_alt=1.
  - 110 or.
  - 111 and.
- arith_mode is ignored unless funct3=000. logic_alt is ignored unless funct3=101.
- Shift amount is rb[log2(XLEN)-1:0]; upper bits of rb are ignored.
- Acceptance occurs when in_valid && in_ready.
- States:
  - IDLE: in_ready=1.
  - SHIFT: iterating; in_ready=0, out_valid=0.
  - DONE: out_valid=1.
- On acceptance of a non-shift op, or a shift with amount 0: the result and both compare flags are registered, and the state goes to DONE.
- On acceptance of a shift with amount > 0:
  - ra is loaded into the shift register, the count is loaded with the amount, and the compare flags are registered.
  - State goes to SHIFT.
  - Each SHIFT cycle shifts by min(count, SHIFT_STEP) and decrements count by the same amount.
  - When count reaches 0 the state goes to DONE.
- sra fills vacated positions with the original ra[XLEN-1] on every step.
- DONE:
  - result and flags hold stable while out_ready=0.
  - out_ready=1 with no new acceptance: state goes to IDLE.
- in_ready = IDLE || (DONE && out_ready). This is a combinational path from out_ready to in_ready. Acceptance in DONE retires the old result and starts the new op in the same edge.
- flush has priority over everything except reset. The next state is IDLE, out_valid goes to 0, and any same-cycle acceptance is discarded. result and flags keep their last values.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, unsigned_compare=0, signed_compare=0, shift count 0.
- Non-shift latency, or shift amount 0: out_valid rises 1 cycle after the acceptance edge.
- Shift latency: 1 + ceil(amount/SHIFT_STEP) cycles. Example, XLEN=32, SHIFT_STEP=4, amount 31: 9 cycles.
- Throughput:
  - 1 op/cycle for non-shift ops with out_ready held at 1.
  - Shifts block issue for ceil(amount/SHIFT_STEP) extra cycles.
- Outputs are registered, except in_ready, which depends on state and out_ready.
- Inputs are sampled only at acceptance. ra, rb and opcode may change freely afterwards.
- Reset asserted mid-shift: returns to reset values immediately, with no output.

## Test plan
- Reset, then add ra=0x7FFFFFFF, rb=1 -> result 0x80000000, out_valid 1 cycle after acceptance. Sub ra=5, rb=7 -> result 0xFFFFFFFE, unsigned_compare=1, signed_compare=1.
- slt ra=0xFFFFFFFF, rb=1 -> result 1. sltu with the same operands -> result 0. xor/or/and with ra=0xF0F0F0F0, rb=0xFF00FF00 -> 0x0FF00FF0, 0xFFF0FFF0, 0xF000F000.
- XLEN=32, SHIFT_STEP=4:
  - sll ra=1, rb=5 -> result 0x20, out_valid 3 cycles after acceptance.
  - sra ra=0x80000000, rb=0xFFFFFFFF (amount 31) -> result 0xFFFFFFFF after 9 cycles.
  - srl with the same operands -> result 0x00000001.
  - sll rb=32 (amount 0) -> result = ra after 1 cycle.
- Hold out_ready=0 for 3 cycles in DONE -> result and flags stable, in_ready=0. Then out_ready=1 with in_valid=1 -> the new op is accepted in the same cycle, and its result appears on the next cycle.
- flush during the 2nd SHIFT cycle of sll rb=20 -> out_valid never asserts, in_ready=1 next cycle. Separately, flush with in_valid=1 in IDLE -> the op is discarded.
- Assert rst_n=0 asynchronously mid-shift -> in_ready=1, out_valid=0, result=0 without waiting for a clk edge.
